// File: rtl/sun_pll_pkg.sv
// Shared widths, types and constants for the SUN_PLL programmable feedback divider.
package sun_pll_pkg;

  localparam int unsigned DIV_W_DEF  = 8;
  localparam int unsigned FRAC_W_DEF = 8;
  localparam int unsigned N_MIN      = 2;

  typedef logic [DIV_W_DEF-1:0]  div_n_t;
  typedef logic [FRAC_W_DEF-1:0] div_frac_t;

endpackage

// File: rtl/sun_pll_frac_acc.sv
// First-order (MASH-1) fractional accumulator; advances once per divider wrap.
module sun_pll_frac_acc
  import sun_pll_pkg::*;
#(
  parameter int unsigned FRAC_W = FRAC_W_DEF
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry,
  output logic              carry_next
);

  logic [FRAC_W-1:0] acc_q;
  logic              carry_q;
  logic [FRAC_W:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, frac};

  always_ff @(posedge ck) begin
    if (rst || clr) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (en) begin
      acc_q   <= sum[FRAC_W-1:0];
      carry_q <= sum[FRAC_W];
    end
  end

  // Carry that will govern the next period, visible before the edge.
  assign carry      = carry_q;
  assign carry_next = clr ? 1'b0 : (en ? sum[FRAC_W] : carry_q);

endmodule

// File: rtl/sun_pll_divn_prog.sv
// Programmable feedback divider CK/N with glitch-free ratio changes at period boundaries.
// Fractional N+F/2^FRAC_W mode is enabled by defining SUN_PLL_DIVN_FRAC_EN.
module sun_pll_divn_prog
  import sun_pll_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned FRAC_W  = FRAC_W_DEF,
  parameter int unsigned N_RESET = 32
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              PWRUP_1V8,
  input  logic              LOAD,
  input  logic [DIV_W-1:0]  DIV_N,
  input  logic [FRAC_W-1:0] DIV_FRAC,
  output logic              CK_FB,
  output logic              TC,
  output logic              LOAD_ACK,
  output logic              DIV_ERR
);

  localparam int unsigned NeW = DIV_W + 1;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] n_act_q, n_nxt;
  logic [DIV_W-1:0] pend_n_q, pend_n_d;
  logic             pend_v_q, pend_v_d;
  logic             pwr_q;
  logic             ck_fb_d, tc_d, err_d;
  logic             carry_cur, carry_nxt;
  logic             restart, wrap, apply, n_low;
  logic [NeW-1:0]   ne_cur, ne_nxt, hi_nxt;
  logic [DIV_W-1:0] ld_n;

  assign n_low   = DIV_N < DIV_W'(N_MIN);
  assign ld_n    = n_low ? DIV_W'(N_MIN) : DIV_N;
  assign ne_cur  = {1'b0, n_act_q} + NeW'(carry_cur);
  assign restart = PWRUP_1V8 && !pwr_q;
  assign wrap    = PWRUP_1V8 && pwr_q && ({1'b0, cnt_q} == ne_cur - NeW'(1));
  assign apply   = pend_v_q && (restart || wrap);
  assign n_nxt   = apply ? pend_n_q : n_act_q;
  assign ne_nxt  = {1'b0, n_nxt} + NeW'(carry_nxt);
  assign hi_nxt  = (ne_nxt + NeW'(1)) >> 1;

`ifdef SUN_PLL_DIVN_FRAC_EN
  logic [FRAC_W-1:0] f_act_q, pend_f_q, f_nxt;

  assign f_nxt = apply ? pend_f_q : f_act_q;

  always_ff @(posedge CK) begin
    if (RST) begin
      f_act_q  <= '0;
      pend_f_q <= '0;
    end else begin
      if (apply) f_act_q <= pend_f_q;
      if (LOAD)  pend_f_q <= DIV_FRAC;
    end
  end

  sun_pll_frac_acc #(
    .FRAC_W(FRAC_W)
  ) u_frac_acc (
    .ck        (CK),
    .rst       (RST),
    .clr       (!PWRUP_1V8),
    .en        (wrap),
    .frac      (f_nxt),
    .carry     (carry_cur),
    .carry_next(carry_nxt)
  );
`else
  logic unused_frac;

  assign unused_frac = ^DIV_FRAC;
  assign carry_cur   = 1'b0;
  assign carry_nxt   = 1'b0;
`endif

  always_comb begin
    cnt_d    = cnt_q + DIV_W'(1);
    pend_n_d = pend_n_q;
    pend_v_d = pend_v_q;
    err_d    = DIV_ERR | (LOAD && n_low);
    if (!PWRUP_1V8 || restart || wrap) cnt_d = '0;
    // A LOAD coinciding with an apply refills pending for the following wrap.
    if (LOAD) begin
      pend_n_d = ld_n;
      pend_v_d = 1'b1;
    end else if (apply) begin
      pend_v_d = 1'b0;
    end
    ck_fb_d = PWRUP_1V8 && ({1'b0, cnt_d} < hi_nxt);
    tc_d    = PWRUP_1V8 && ({1'b0, cnt_d} == ne_nxt - NeW'(1));
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      cnt_q    <= '0;
      n_act_q  <= DIV_W'(N_RESET);
      pend_n_q <= DIV_W'(N_RESET);
      pend_v_q <= 1'b0;
      pwr_q    <= 1'b1;
      CK_FB    <= 1'b0;
      TC       <= 1'b0;
      LOAD_ACK <= 1'b0;
      DIV_ERR  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      n_act_q  <= n_nxt;
      pend_n_q <= pend_n_d;
      pend_v_q <= pend_v_d;
      pwr_q    <= PWRUP_1V8;
      CK_FB    <= ck_fb_d;
      TC       <= tc_d;
      LOAD_ACK <= apply;
      DIV_ERR  <= err_d;
    end
  end

endmodule

// File: tb/tb_sun_pll_divn_prog.sv
// Directed self-checking bench for sun_pll_divn_prog (period, duty, TC, ACK, error, power-down).
module tb_sun_pll_divn_prog;

  logic       CK = 1'b0;
  logic       RST, PWRUP_1V8, LOAD;
  logic [7:0] DIV_N, DIV_FRAC;
  logic       CK_FB, TC, LOAD_ACK, DIV_ERR;

  int errors = 0;
  int checks = 0;

  sun_pll_divn_prog dut (
    .CK       (CK),
    .RST      (RST),
    .PWRUP_1V8(PWRUP_1V8),
    .LOAD     (LOAD),
    .DIV_N    (DIV_N),
    .DIV_FRAC (DIV_FRAC),
    .CK_FB    (CK_FB),
    .TC       (TC),
    .LOAD_ACK (LOAD_ACK),
    .DIV_ERR  (DIV_ERR)
  );

  always #5 CK = ~CK;

  // Advance to the next TC cycle (at least one cycle), bounded.
  task automatic wait_tc();
    int n;
    n = 0;
    do begin
      @(negedge CK);
      n++;
    end while (!TC && n < 600);
    checks++;
    if (!TC) begin
      errors++;
      $display("FAIL wait_tc: TC=%0b after %0d cycles, required TC=1", TC, n);
    end
  endtask

  // From a TC cycle, measure the following period up to and including its TC.
  task automatic measure(output int len, output int hi, output int ack);
    len = 0; hi = 0; ack = 0;
    do begin
      @(negedge CK);
      len++;
      hi  += int'(CK_FB);
      ack += int'(LOAD_ACK);
    end while (!TC && len < 600);
  endtask

  task automatic do_load(input logic [7:0] n, input logic [7:0] f);
    LOAD = 1'b1; DIV_N = n; DIV_FRAC = f;
    @(negedge CK);
    LOAD = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; PWRUP_1V8 = 1'b1; LOAD = 1'b0; DIV_N = 8'd0; DIV_FRAC = 8'd0;
    repeat (2) @(negedge CK);
    checks++;
    if ({CK_FB, TC, LOAD_ACK, DIV_ERR} !== 4'b0000) begin
      errors++;
      $display("FAIL reset: {CK_FB,TC,ACK,ERR}=%b required 0000", {CK_FB, TC, LOAD_ACK, DIV_ERR});
    end
    RST = 1'b0;
  endtask

  task automatic test_default();
    int len, hi, ack;
    wait_tc();
    for (int p = 0; p < 3; p++) begin
      measure(len, hi, ack);
      checks++;
      if (len !== 32 || hi !== 16 || ack !== 0) begin
        errors++;
        $display("FAIL default p%0d: len=%0d hi=%0d ack=%0d required 32/16/0", p, len, hi, ack);
      end
    end
  endtask

  task automatic test_load5();
    int len, hi, ack;
    logic tc_end;
    wait_tc();
    for (int i = 0; i < 32; i++) begin
      @(negedge CK);
      if (i == 10) begin LOAD = 1'b1; DIV_N = 8'd5; end
      if (i == 11) LOAD = 1'b0;
    end
    tc_end = TC;
    checks++;
    if (tc_end !== 1'b1) begin
      errors++;
      $display("FAIL load5 old period: TC=%b at cycle 31, required 1", tc_end);
    end
    for (int p = 0; p < 2; p++) begin
      measure(len, hi, ack);
      checks++;
      if (len !== 5 || hi !== 3 || ack !== (p == 0 ? 1 : 0)) begin
        errors++;
        $display("FAIL load5 p%0d: len=%0d hi=%0d ack=%0d required 5/3/%0d",
                 p, len, hi, ack, (p == 0 ? 1 : 0));
      end
    end
  endtask

  task automatic test_overwrite_and_clamp();
    int len, hi, ack;
    wait_tc();
    @(negedge CK);
    LOAD = 1'b1; DIV_N = 8'd7;
    @(negedge CK);
    DIV_N = 8'd11;
    @(negedge CK);
    LOAD = 1'b0;
    wait_tc();
    for (int p = 0; p < 2; p++) begin
      measure(len, hi, ack);
      checks++;
      if (len !== 11 || hi !== 6 || ack !== (p == 0 ? 1 : 0)) begin
        errors++;
        $display("FAIL overwrite p%0d: len=%0d hi=%0d ack=%0d required 11/6/%0d",
                 p, len, hi, ack, (p == 0 ? 1 : 0));
      end
    end
    checks++;
    if (DIV_ERR !== 1'b0) begin
      errors++;
      $display("FAIL err_before: DIV_ERR=%b required 0", DIV_ERR);
    end
    @(negedge CK);
    do_load(8'd1, 8'd0);
    wait_tc();
    for (int p = 0; p < 2; p++) begin
      measure(len, hi, ack);
      checks++;
      if (len !== 2 || hi !== 1 || ack !== (p == 0 ? 1 : 0)) begin
        errors++;
        $display("FAIL clamp p%0d: len=%0d hi=%0d ack=%0d required 2/1/%0d",
                 p, len, hi, ack, (p == 0 ? 1 : 0));
      end
    end
    checks++;
    if (DIV_ERR !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: DIV_ERR=%b required 1", DIV_ERR);
    end
  endtask

  task automatic test_pwrdown();
    int len, hi;
    wait_tc();
    repeat (21) @(negedge CK);
    PWRUP_1V8 = 1'b0;
    @(negedge CK);
    checks++;
    if (CK_FB !== 1'b0 || TC !== 1'b0) begin
      errors++;
      $display("FAIL pwrdown: CK_FB=%b TC=%b required 0/0", CK_FB, TC);
    end
    repeat (2) @(negedge CK);
    PWRUP_1V8 = 1'b1;
    @(negedge CK);
    checks++;
    if (CK_FB !== 1'b1 || LOAD_ACK !== 1'b0) begin
      errors++;
      $display("FAIL restart: CK_FB=%b ACK=%b required 1/0", CK_FB, LOAD_ACK);
    end
    len = 1; hi = 1;
    while (!TC && len < 600) begin
      @(negedge CK);
      len++;
      hi += int'(CK_FB);
    end
    checks++;
    if (len !== 32 || hi !== 16) begin
      errors++;
      $display("FAIL restart period: len=%0d hi=%0d required 32/16", len, hi);
    end
  endtask

  task automatic test_load_at_wrap();
    int len, hi, ack;
    wait_tc();
    do_load(8'd6, 8'd0);
    len = 1; ack = int'(LOAD_ACK);
    while (!TC && len < 600) begin
      @(negedge CK);
      len++;
      ack += int'(LOAD_ACK);
    end
    checks++;
    if (len !== 32 || ack !== 0) begin
      errors++;
      $display("FAIL wrap_load old: len=%0d ack=%0d required 32/0", len, ack);
    end
    measure(len, hi, ack);
    checks++;
    if (len !== 6 || hi !== 3 || ack !== 1) begin
      errors++;
      $display("FAIL wrap_load new: len=%0d hi=%0d ack=%0d required 6/3/1", len, hi, ack);
    end
  endtask

  task automatic test_frac();
    int len, hi, ack, total;
    int exp_len[4];
`ifdef SUN_PLL_DIVN_FRAC_EN
    exp_len = '{10, 10, 10, 11};
`else
    exp_len = '{10, 10, 10, 10};
`endif
    wait_tc();
    @(negedge CK);
    do_load(8'd10, 8'd64);
    wait_tc();
    total = 0;
    for (int p = 0; p < 4; p++) begin
      measure(len, hi, ack);
      total += len;
      checks++;
      if (len !== exp_len[p]) begin
        errors++;
        $display("FAIL frac p%0d: len=%0d required %0d", p, len, exp_len[p]);
      end
    end
    checks++;
    if (total !== exp_len[0] + exp_len[1] + exp_len[2] + exp_len[3]) begin
      errors++;
      $display("FAIL frac total: %0d cycles per 4 TC required %0d", total,
               exp_len[0] + exp_len[1] + exp_len[2] + exp_len[3]);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_load5();
    test_overwrite_and_clamp();
    test_reset();
    test_pwrdown();
    test_load_at_wrap();
    test_frac();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
